// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush scheduler.
package pipe_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_FILL = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_DEF = 64;
   localparam int unsigned CNT_W_DEF   = 16;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/miss inputs and pipeline control outputs of the stall scheduler.
interface pipe_stall_ctrl_if
   import pipe_stall_ctrl_pkg::*;
   #(parameter int unsigned CNT_W = CNT_W_DEF);

   logic             ld_use_i;
   logic             branch_i;
   logic             dmiss_i;
   logic             mem_ack_i;
   logic             mem_req_o;
   logic             pc_we_o;
   logic             ifid_we_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             exmem_we_o;
   logic             memwb_bubble_o;
   logic             busy_o;
   logic             err_o;
   logic [CNT_W-1:0] stall_cnt_o;

   // Pipeline / memory side
   modport master (
      output ld_use_i, branch_i, dmiss_i, mem_ack_i,
      input  mem_req_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
             exmem_we_o, memwb_bubble_o, busy_o, err_o, stall_cnt_o
   );

   // Scheduler side
   modport slave (
      input  ld_use_i, branch_i, dmiss_i, mem_ack_i,
      output mem_req_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
             exmem_we_o, memwb_bubble_o, busy_o, err_o, stall_cnt_o
   );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Merges load-use, branch and D-cache miss events into per-stage enables;
// sequences the miss refill with a watchdog and counts stalled cycles.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pipe_stall_ctrl_if.slave bus
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   state_e           state_q;
   state_e           state_d;
   logic             err_q;
   logic             err_d;
   logic [TMR_W-1:0] timer;
   logic             in_wait;

   logic pc_we_c, ifid_we_c, exmem_we_c, idex_bubble_c, memwb_bubble_c;
   logic ifid_flush_c, mem_req_c, busy_c;

   assign in_wait = (state_q == ST_WAIT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (bus.dmiss_i) state_d = ST_WAIT;
         ST_WAIT: if (bus.mem_ack_i) state_d = ST_FILL;
         ST_FILL: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Mealy decode; reset forces a safe frozen-with-bubbles pattern
   always_comb begin
      pc_we_c        = 1'b1;
      ifid_we_c      = 1'b1;
      exmem_we_c     = 1'b1;
      idex_bubble_c  = 1'b0;
      memwb_bubble_c = 1'b0;
      ifid_flush_c   = 1'b0;
      mem_req_c      = 1'b0;
      busy_c         = 1'b0;
      if (rst_i) begin
         pc_we_c        = 1'b0;
         ifid_we_c      = 1'b0;
         exmem_we_c     = 1'b0;
         idex_bubble_c  = 1'b1;
         memwb_bubble_c = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.dmiss_i) begin
                  pc_we_c        = 1'b0;
                  ifid_we_c      = 1'b0;
                  exmem_we_c     = 1'b0;
                  memwb_bubble_c = 1'b1;
                  mem_req_c      = 1'b1;
               end else if (bus.ld_use_i) begin
                  pc_we_c       = 1'b0;
                  ifid_we_c     = 1'b0;
                  idex_bubble_c = 1'b1;
               end else if (bus.branch_i) begin
                  ifid_flush_c = 1'b1;
               end
            end
            ST_WAIT, ST_FILL: begin
               pc_we_c        = 1'b0;
               ifid_we_c      = 1'b0;
               exmem_we_c     = 1'b0;
               memwb_bubble_c = 1'b1;
               mem_req_c      = in_wait;
               busy_c         = 1'b1;
            end
            default: begin
               pc_we_c    = 1'b0;
               ifid_we_c  = 1'b0;
               exmem_we_c = 1'b0;
            end
         endcase
      end
   end

   // Watchdog runs only while waiting without an ack
   sat_counter #(.W(TMR_W)) u_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (in_wait && !bus.mem_ack_i),
      .clr_i (!in_wait || bus.mem_ack_i),
      .cnt_o (timer)
   );

   // Set on the edge where the timer advances to TIMEOUT-1
   always_comb begin
      err_d = err_q;
      if (in_wait && !bus.mem_ack_i && (timer >= TMR_W'(TIMEOUT - 2))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (!pc_we_c),
      .clr_i (1'b0),
      .cnt_o (bus.stall_cnt_o)
   );

   assign bus.pc_we_o        = pc_we_c;
   assign bus.ifid_we_o      = ifid_we_c;
   assign bus.exmem_we_o     = exmem_we_c;
   assign bus.idex_bubble_o  = idex_bubble_c;
   assign bus.memwb_bubble_o = memwb_bubble_c;
   assign bus.ifid_flush_o   = ifid_flush_c;
   assign bus.mem_req_o      = mem_req_c;
   assign bus.busy_o         = busy_c;
   assign bus.err_o          = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench: default-parameter instance A plus a TIMEOUT=4/CNT_W=3 instance B.
module tb_pipe_stall_ctrl;

   logic clk;
   logic rst;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   pipe_stall_ctrl_if #(.CNT_W(16)) ifa ();
   pipe_stall_ctrl_if #(.CNT_W(3))  ifb ();

   pipe_stall_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifa)
   );

   pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one cycle; inputs are then driven 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ifa.ld_use_i = 0; ifa.branch_i = 0; ifa.dmiss_i = 0; ifa.mem_ack_i = 0;
   endtask

   task automatic idle_b();
      ifb.ld_use_i = 0; ifb.branch_i = 0; ifb.dmiss_i = 0; ifb.mem_ack_i = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle_a();
      idle_b();
      ifa.dmiss_i = 1'b1;
      #3;
      check_eq("rst_pc_we",      32'(ifa.pc_we_o), 0);
      check_eq("rst_idex_bub",   32'(ifa.idex_bubble_o), 1);
      check_eq("rst_memwb_bub",  32'(ifa.memwb_bubble_o), 1);
      check_eq("rst_mem_req",    32'(ifa.mem_req_o), 0);
      check_eq("rst_busy",       32'(ifa.busy_o), 0);
      check_eq("rst_stall_cnt",  32'(ifa.stall_cnt_o), 0);
      idle_a();
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      check_eq("run_pc_we",      32'(ifa.pc_we_o), 1);
      check_eq("run_ifid_we",    32'(ifa.ifid_we_o), 1);
      check_eq("run_exmem_we",   32'(ifa.exmem_we_o), 1);
      check_eq("run_idex_bub",   32'(ifa.idex_bubble_o), 0);
      check_eq("run_memwb_bub",  32'(ifa.memwb_bubble_o), 0);
      check_eq("run_flush",      32'(ifa.ifid_flush_o), 0);
      check_eq("run_stall_cnt",  32'(ifa.stall_cnt_o), 0);

      // Load-use single-cycle stall
      cyc(); ifa.ld_use_i = 1; #1;
      check_eq("lu_pc_we",       32'(ifa.pc_we_o), 0);
      check_eq("lu_ifid_we",     32'(ifa.ifid_we_o), 0);
      check_eq("lu_idex_bub",    32'(ifa.idex_bubble_o), 1);
      check_eq("lu_exmem_we",    32'(ifa.exmem_we_o), 1);
      cyc(); ifa.ld_use_i = 0; #1;
      check_eq("lu_done_pc_we",  32'(ifa.pc_we_o), 1);
      check_eq("lu_done_bub",    32'(ifa.idex_bubble_o), 0);
      check_eq("lu_stall_cnt",   32'(ifa.stall_cnt_o), 1);

      // Load-use beats branch, then branch alone flushes
      cyc(); ifa.ld_use_i = 1; ifa.branch_i = 1; #1;
      check_eq("lub_pc_we",      32'(ifa.pc_we_o), 0);
      check_eq("lub_flush",      32'(ifa.ifid_flush_o), 0);
      check_eq("lub_idex_bub",   32'(ifa.idex_bubble_o), 1);
      cyc(); ifa.ld_use_i = 0; #1;
      check_eq("br_flush",       32'(ifa.ifid_flush_o), 1);
      check_eq("br_pc_we",       32'(ifa.pc_we_o), 1);
      check_eq("br_stall_cnt",   32'(ifa.stall_cnt_o), 2);

      // Miss with all events; ack on the 5th WAIT cycle
      cyc(); ifa.dmiss_i = 1; ifa.ld_use_i = 1; ifa.branch_i = 1; #1;
      check_eq("miss_req",       32'(ifa.mem_req_o), 1);
      check_eq("miss_pc_we",     32'(ifa.pc_we_o), 0);
      check_eq("miss_exmem_we",  32'(ifa.exmem_we_o), 0);
      check_eq("miss_memwb_bub", 32'(ifa.memwb_bubble_o), 1);
      check_eq("miss_flush",     32'(ifa.ifid_flush_o), 0);
      check_eq("miss_idex_bub",  32'(ifa.idex_bubble_o), 0);
      check_eq("miss_busy",      32'(ifa.busy_o), 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(); ifa.ld_use_i = 0; ifa.branch_i = 0; ifa.mem_ack_i = (i == 5); #1;
         check_eq($sformatf("wait%0d_req", i),  32'(ifa.mem_req_o), 1);
         check_eq($sformatf("wait%0d_busy", i), 32'(ifa.busy_o), 1);
         check_eq($sformatf("wait%0d_pc", i),   32'(ifa.pc_we_o), 0);
      end
      cyc(); ifa.mem_ack_i = 0; ifa.dmiss_i = 0; #1;
      check_eq("fill_req",       32'(ifa.mem_req_o), 0);
      check_eq("fill_busy",      32'(ifa.busy_o), 1);
      check_eq("fill_pc_we",     32'(ifa.pc_we_o), 0);
      check_eq("fill_memwb_bub", 32'(ifa.memwb_bubble_o), 1);
      cyc(); #1;
      check_eq("post_busy",      32'(ifa.busy_o), 0);
      check_eq("post_pc_we",     32'(ifa.pc_we_o), 1);
      check_eq("post_stall_cnt", 32'(ifa.stall_cnt_o), 9);
      check_eq("post_err",       32'(ifa.err_o), 0);

      // Stray ack in RUN is ignored
      cyc(); ifa.mem_ack_i = 1; #1;
      check_eq("stray_ack_pc_we", 32'(ifa.pc_we_o), 1);
      cyc(); ifa.mem_ack_i = 0; #1;
      check_eq("stray_ack_busy", 32'(ifa.busy_o), 0);

      // Reset abandons a refill
      cyc(); ifa.dmiss_i = 1; #1;
      cyc(); #1;
      check_eq("rw_busy_pre",    32'(ifa.busy_o), 1);
      rst = 1'b1; #1;
      check_eq("rw_req_async",   32'(ifa.mem_req_o), 0);
      check_eq("rw_busy_async",  32'(ifa.busy_o), 0);
      ifa.dmiss_i = 0;
      cyc(); rst = 1'b0; #1;
      check_eq("rw_post_busy",   32'(ifa.busy_o), 0);
      check_eq("rw_post_pc_we",  32'(ifa.pc_we_o), 1);
      check_eq("rw_post_err",    32'(ifa.err_o), 0);
      check_eq("rw_post_cnt",    32'(ifa.stall_cnt_o), 0);

      // Instance B: watchdog with TIMEOUT=4
      cyc(); ifb.dmiss_i = 1; #1;
      check_eq("to_run_err",     32'(ifb.err_o), 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(); #1;
         check_eq($sformatf("to_wait%0d_err", i), 32'(ifb.err_o), (i >= 4) ? 1 : 0);
         check_eq($sformatf("to_wait%0d_busy", i), 32'(ifb.busy_o), 1);
      end
      cyc(); ifb.mem_ack_i = 1; #1;
      check_eq("to_ack_req",     32'(ifb.mem_req_o), 1);
      cyc(); ifb.mem_ack_i = 0; ifb.dmiss_i = 0; #1;
      check_eq("to_fill_busy",   32'(ifb.busy_o), 1);
      cyc(); #1;
      check_eq("to_run_busy",    32'(ifb.busy_o), 0);
      check_eq("to_sticky_err",  32'(ifb.err_o), 1);
      check_eq("to_cnt_sat",     32'(ifb.stall_cnt_o), 7);

      // Instance B: 3-bit stall counter saturation from a fresh reset
      rst = 1'b1; #1;
      check_eq("b_rst_err",      32'(ifb.err_o), 0);
      check_eq("b_rst_cnt",      32'(ifb.stall_cnt_o), 0);
      cyc(); rst = 1'b0; ifb.ld_use_i = 1; #1;
      for (int i = 1; i <= 10; i++) begin
         cyc(); #1;
         if (i == 6) check_eq("sat_cnt_6", 32'(ifb.stall_cnt_o), 6);
      end
      ifb.ld_use_i = 0;
      cyc(); #1;
      check_eq("sat_cnt_final",  32'(ifb.stall_cnt_o), 7);
      check_eq("sat_err",        32'(ifb.err_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
